// File: rtl/remote_pkg.sv
// Shared constants and types for the remote-memory responder.
package remote_pkg;

    // Memory-mapped output register address (feeds the output FIFO)
    localparam logic [15:0] REMOTE_IO_ADDR = 16'hFFFF;

    // Responder FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/remote_out_fifo.sv
// Small synchronous FIFO behind the memory-mapped output register.
// Flags and the head word are registered so every output comes from a flop.
module remote_out_fifo
    import remote_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_en;
    logic             pop_en;

    // Next-state for pointers, occupancy, flags and the registered head word
    always_comb begin
        push_en  = push && !full_q;
        pop_en   = pop && !empty_q;
        wr_ptr_d = push_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_en) - CW'(pop_en);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        // The new head may be the word being written on this same edge
        if (count_d == '0) begin
            head_d = head_q;
        end else if (push_en && (rd_ptr_d == wr_ptr_q)) begin
            head_d = push_data;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    // Storage array; contents are not reset
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Control and head registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/remote_responder.sv
// Responder end of the core's remote-memory port: local RAM with
// programmable wait states plus a memory-mapped output FIFO at 16'hFFFF.
module remote_responder
    import remote_pkg::*;
#(
    parameter int MEM_WORDS      = 1024,
    parameter int WAIT_STATES    = 2,
    parameter int OUT_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        remote_wren,
    input  logic        remote_rden,
    input  logic [15:0] remote_addr,
    input  logic [15:0] remote_write_val,
    output logic        remote_ready,
    output logic [15:0] remote_read_val,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(OUT_FIFO_DEPTH) + 1;

    logic [15:0] data [MEM_WORDS];

    logic [1:0]  state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic [15:0] rdata_q, rdata_d;

    logic          is_io;
    logic          can_complete;
    logic          ram_we;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [15:0]   fifo_head;
    logic [AW-1:0] ram_idx;

    assign is_io   = (addr_q == REMOTE_IO_ADDR);
    assign ram_idx = addr_q[AW-1:0];
    // Only an I/O write into a full FIFO can stall; uses the registered full flag
    assign can_complete = !((op_q == OP_WRITE) && is_io && fifo_full);
    assign fifo_pop = out_ready && !fifo_empty;

    // Request FSM: latch in IDLE, count down in WAIT, complete on entry to ACK
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        ram_we    = 1'b0;
        fifo_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (remote_wren || remote_rden) begin
                    op_d    = remote_wren ? OP_WRITE : OP_READ;
                    addr_d  = remote_addr;
                    wdata_d = remote_write_val;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (can_complete) begin
                    state_d = ST_ACK;
                    ready_d = 1'b1;
                    if (op_q == OP_WRITE) begin
                        if (is_io) begin
                            fifo_push = 1'b1;
                        end else begin
                            ram_we = 1'b1;
                        end
                    end else if (is_io) begin
                        rdata_d = 16'(fifo_count) & 16'h000F;
                    end else begin
                        rdata_d = data[ram_idx];
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Remote RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            data[ram_idx] <= wdata_q;
        end
    end

    // FSM, request latches and registered responses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    remote_out_fifo #(
        .DEPTH (OUT_FIFO_DEPTH),
        .WIDTH (16)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (wdata_q),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign remote_ready    = ready_q;
    assign remote_read_val = rdata_q;
    assign out_valid       = !fifo_empty;
    assign out_data        = fifo_head;

endmodule

// File: tb/tb_remote_responder.sv
// Scoreboard bench for remote_responder: instance 0 uses 2 wait states,
// instance 1 uses 0 wait states for back-to-back timing.
module tb_remote_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wren   [2];
    logic        rden   [2];
    logic [15:0] addr   [2];
    logic [15:0] wval   [2];
    logic        ready  [2];
    logic [15:0] rval   [2];
    logic        ovalid [2];
    logic [15:0] odata  [2];
    logic        oready [2];

    logic [15:0] rd_q  [$];
    logic [15:0] out_q [$];
    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    remote_responder #(.MEM_WORDS(1024), .WAIT_STATES(2), .OUT_FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .remote_wren(wren[0]), .remote_rden(rden[0]),
        .remote_addr(addr[0]), .remote_write_val(wval[0]),
        .remote_ready(ready[0]), .remote_read_val(rval[0]),
        .out_valid(ovalid[0]), .out_data(odata[0]), .out_ready(oready[0])
    );

    remote_responder #(.MEM_WORDS(1024), .WAIT_STATES(0), .OUT_FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset(reset),
        .remote_wren(wren[1]), .remote_rden(rden[1]),
        .remote_addr(addr[1]), .remote_write_val(wval[1]),
        .remote_ready(ready[1]), .remote_read_val(rval[1]),
        .out_valid(ovalid[1]), .out_data(odata[1]), .out_ready(oready[1])
    );

    // Issue one request at a negedge, wait for the ack, check latency/data/pulse.
    task automatic do_req(input int s, input bit wr, input bit rd, input logic [15:0] a,
                          input logic [15:0] d, input int exp_lat, input logic [15:0] exp_rd,
                          output int ack_cyc);
        int cyc;
        bit got;
        logic [15:0] exp;
        wren[s] = wr;
        rden[s] = rd;
        addr[s] = a;
        wval[s] = d;
        if (!wr) rd_q.push_back(exp_rd);
        if (wr && a == 16'hFFFF) out_q.push_back(d);
        cyc = 0;
        got = 0;
        ack_cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (ready[s] === 1'b1) got = 1;
        end
        ack_cyc = cyc_cnt;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout dut%0d addr=%h: no remote_ready within 50 cycles", s, a);
            if (!wr && rd_q.size() > 0) exp = rd_q.pop_front();
        end else begin
            checks++;
            if (cyc != exp_lat) begin
                errors++;
                $display("FAIL ack_latency dut%0d addr=%h: got %0d cycles, expected %0d", s, a, cyc, exp_lat);
            end
            if (!wr) begin
                exp = rd_q.pop_front();
                checks++;
                if (rval[s] !== exp) begin
                    errors++;
                    $display("FAIL read_data dut%0d addr=%h: got %h, expected %h", s, a, rval[s], exp);
                end
            end
        end
        wren[s] = 1'b0;
        rden[s] = 1'b0;
        @(negedge clk);
        checks++;
        if (ready[s] !== 1'b0) begin
            errors++;
            $display("FAIL ready_pulse dut%0d: remote_ready=%b one cycle after ack, expected 0", s, ready[s]);
        end
    endtask

    // Check and pop the FIFO head through the valid/ready handshake.
    task automatic pop_one(input int s);
        logic [15:0] exp;
        checks++;
        if (ovalid[s] !== 1'b1) begin
            errors++;
            $display("FAIL out_valid dut%0d: got %b, expected 1", s, ovalid[s]);
        end else if (out_q.size() > 0) begin
            exp = out_q.pop_front();
            checks++;
            if (odata[s] !== exp) begin
                errors++;
                $display("FAIL out_data dut%0d: got %h, expected %h", s, odata[s], exp);
            end
        end
        oready[s] = 1'b1;
        @(negedge clk);
        oready[s] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (ready[s] !== 1'b0 || ovalid[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d: ready=%b out_valid=%b, expected 0/0", s, ready[s], ovalid[s]);
            end
            checks++;
            if (rval[s] !== 16'h0000 || odata[s] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_data dut%0d: read_val=%h out_data=%h, expected 0000/0000", s, rval[s], odata[s]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int t;
        do_req(0, 1'b1, 1'b0, 16'd5, 16'h1234, 4, 16'h0, t);
        do_req(0, 1'b0, 1'b1, 16'd5, 16'h0, 4, 16'h1234, t);
    endtask

    task automatic test_both_high();
        int t;
        do_req(0, 1'b1, 1'b1, 16'd7, 16'hBEEF, 4, 16'h0, t);
        do_req(0, 1'b0, 1'b1, 16'd7, 16'h0, 4, 16'hBEEF, t);
    endtask

    task automatic test_alias();
        int t;
        do_req(0, 1'b1, 1'b0, 16'd1027, 16'hC3C3, 4, 16'h0, t);
        do_req(0, 1'b0, 1'b1, 16'd3, 16'h0, 4, 16'hC3C3, t);
    endtask

    task automatic test_back_to_back();
        int t;
        int prev;
        for (int i = 0; i < 4; i++)
            do_req(1, 1'b1, 1'b0, 16'(i), 16'hA0 + 16'(i), 2, 16'h0, t);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(1, 1'b0, 1'b1, 16'(i), 16'h0, 2, 16'hA0 + 16'(i), t);
            if (i > 0) begin
                checks++;
                if (t - prev != 3) begin
                    errors++;
                    $display("FAIL b2b_spacing read %0d: got %0d cycles between acks, expected 3", i, t - prev);
                end
            end
            prev = t;
        end
    endtask

    task automatic test_fifo_stall();
        int t;
        int cyc;
        bit got;
        for (int i = 1; i <= 4; i++)
            do_req(0, 1'b1, 1'b0, 16'hFFFF, 16'(i), 4, 16'h0, t);
        // Fifth write must stall while the FIFO is full
        wren[0] = 1'b1;
        addr[0] = 16'hFFFF;
        wval[0] = 16'd5;
        out_q.push_back(16'd5);
        got = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready[0] === 1'b1) got = 1;
        end
        checks++;
        if (got) begin
            errors++;
            $display("FAIL fifo_stall: remote_ready=1 seen while FIFO full, expected 0");
        end
        pop_one(0);
        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            if (ready[0] === 1'b1) got = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (!got || cyc != 1) begin
            errors++;
            $display("FAIL stall_release: ack after %0d cycles (seen=%0d), expected 1", cyc, got);
        end
        wren[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) pop_one(0);
        checks++;
        if (ovalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drained: out_valid=%b, expected 0", ovalid[0]);
        end
    endtask

    task automatic test_fifo_count();
        int t;
        do_req(0, 1'b1, 1'b0, 16'hFFFF, 16'h000A, 4, 16'h0, t);
        do_req(0, 1'b1, 1'b0, 16'hFFFF, 16'h000B, 4, 16'h0, t);
        do_req(0, 1'b0, 1'b1, 16'hFFFF, 16'h0, 4, 16'h0002, t);
        pop_one(0);
        pop_one(0);
    endtask

    task automatic test_reset_abort();
        int t;
        bit got;
        do_req(0, 1'b1, 1'b0, 16'd9, 16'h0000, 4, 16'h0, t);
        wren[0] = 1'b1;
        addr[0] = 16'd9;
        wval[0] = 16'h5555;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        got = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready[0] === 1'b1) got = 1;
        end
        checks++;
        if (got || ovalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: ready seen=%0d out_valid=%b, expected 0/0", got, ovalid[0]);
        end
        wren[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        do_req(0, 1'b0, 1'b1, 16'd9, 16'h0, 4, 16'h0000, t);
        checks++;
        if (ovalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_fifo: out_valid=%b, expected 0", ovalid[0]);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            wren[s] = 1'b0;
            rden[s] = 1'b0;
            addr[s] = 16'h0;
            wval[s] = 16'h0;
            oready[s] = 1'b0;
        end
        reset = 1'b0;
        test_reset();
        test_write_read();
        test_both_high();
        test_alias();
        test_back_to_back();
        test_fifo_stall();
        test_fifo_count();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
